// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_device_tx
// Description : PS/2 device-side transmitter. Scan codes are queued in a
//               FIFO and sent as 11-bit frames (start, D0..D7, odd parity,
//               stop) on self-generated PS2_CLK / PS2_DATA. A host inhibit
//               aborts the byte in flight, which is kept and resent.
//               Optional macro PS2_ERR_INJECT_EN adds the ERR_INJECT port,
//               which inverts the parity bit of the frame loaded while high.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_device_tx #(
  parameter int CLK_HALF = 2048,
  parameter int SETUP    = 1024,
  parameter int GAP      = 4096,
  parameter int DEPTH    = 16
) (
  input  logic                     CLK100MHZ,
  input  logic                     CPU_RESETN,
  input  logic                     WR_EN,
  input  logic [7:0]               WR_DATA,
  input  logic                     PS2_INHIBIT,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY,
  output logic                     OVERFLOW,
  output logic                     PS2_CLK,
  output logic                     PS2_DATA
`ifdef PS2_ERR_INJECT_EN
  ,
  input  logic                     ERR_INJECT
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Phase counters load LEN-1 and count down to zero, so a phase lasts LEN cycles.
  localparam logic [15:0] c_setup_ld = 16'(SETUP - 1);
  localparam logic [15:0] c_half_ld  = 16'(CLK_HALF - 1);
  localparam logic [15:0] c_gap_ld   = 16'(GAP - 1);
  localparam logic [3:0]  c_last_bit = 4'd10;
  localparam logic [AW:0] c_depth    = (AW + 1)'(DEPTH);
  localparam logic [AW:0] c_cnt_one  = (AW + 1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_GAP   = 3'd4,
    S_INHIB = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [10:0]   r_shift;
  logic [3:0]    r_idx;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full, r_overflow, r_busy, r_ps2_clk, r_ps2_data;
  logic          w_push, w_pop, w_load, w_shift, w_abort, w_par, w_inject, w_data_nxt;
  logic [7:0]    w_head;

  assign w_head = r_mem[r_rd_ptr];

`ifdef PS2_ERR_INJECT_EN
  assign w_inject = ERR_INJECT;
`else
  assign w_inject = 1'b0;
`endif

  assign w_par   = ~(^w_head) ^ w_inject;
  // FULL is the registered flag, so a write in the same cycle as a pop from a full FIFO is dropped.
  assign w_push  = WR_EN & ~r_full;
  // The stop bit (index 10) is never aborted: the frame is already committed.
  assign w_abort = PS2_INHIBIT & (r_idx != c_last_bit);

  // FIFO occupancy for the next cycle, including the byte still in flight.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // Next-state, phase counter reload and frame load/shift/pop strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !PS2_INHIBIT) begin
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = c_setup_ld;
          w_load      = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_abort) begin
          w_state_nxt = S_INHIB;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = c_half_ld;
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      S_LOW: begin
        if (w_abort) begin
          w_state_nxt = S_INHIB;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = c_half_ld;
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      S_HIGH: begin
        if (w_abort) begin
          w_state_nxt = S_INHIB;
        end else if (r_cnt == '0) begin
          if (r_idx == c_last_bit) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = c_gap_ld;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = c_setup_ld;
            w_shift     = 1'b1;
          end
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - 16'd1;
        end
      end
      S_INHIB: begin
        if (!PS2_INHIBIT) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_gap_ld;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Data line value for the next cycle: the current frame bit while framing, else idle high.
  always_comb begin
    w_data_nxt = 1'b1;
    if (w_load) begin
      w_data_nxt = 1'b0;
    end else if (w_shift) begin
      w_data_nxt = r_shift[1];
    end else if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_LOW) ||
                 (w_state_nxt == S_HIGH)) begin
      w_data_nxt = r_shift[0];
    end
  end

  // State and phase counter registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Frame shift register and bit index; loaded from the FIFO head at frame start.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_shift <= '1;
      r_idx   <= '0;
    end else if (w_load) begin
      r_shift <= {1'b1, w_par, w_head, 1'b0};
      r_idx   <= '0;
    end else if (w_shift) begin
      r_shift <= {1'b1, r_shift[10:1]};
      r_idx   <= r_idx + 4'd1;
    end
  end

  // FIFO storage; the head entry is only released by the pop after its stop bit.
  always_ff @(posedge CLK100MHZ) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_depth);
      if (WR_EN && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Registered line and status outputs so no input reaches a pin combinationally.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_ps2_clk  <= (w_state_nxt != S_LOW);
      r_ps2_data <= w_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign FULL     = r_full;
  assign COUNT    = r_count;
  assign BUSY     = r_busy;
  assign OVERFLOW = r_overflow;
  assign PS2_CLK  = r_ps2_clk;
  assign PS2_DATA = r_ps2_data;

endmodule
`default_nettype wire
